// File: rtl/nv_nvdla_sdp_brdma_issue_sched.sv
// Bias-read DMA issue scheduler: reserves latency-buffer credits per command,
// issues a DMA read request plus a context-queue entry, and sequences one layer.
//
// state | meaning
// IDLE  | waiting for op_en; counters and error flag hold
// RUN   | accepting commands until the one flagged cmd_last
// DRAIN | no new commands; waiting for all credits and context entries to return
// DONE  | op_done pulse for one cycle, then back to IDLE
module nv_nvdla_sdp_brdma_issue_sched #(
    parameter int ADDR_W    = 64,
    parameter int LAT_DEPTH = 160,
    parameter int CQ_DEPTH  = 160
) (
    input  logic                nvdla_core_clk_mgated,
    input  logic                nvdla_core_rstn,
    input  logic                op_en,
    input  logic                cmd_pvld,
    output logic                cmd_prdy,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_size,
    input  logic                cmd_last,
    output logic                dma_rd_req_pvld,
    input  logic                dma_rd_req_prdy,
    output logic [ADDR_W+14:0]  dma_rd_req_pd,
    output logic                ig2cq_pvld,
    input  logic                ig2cq_prdy,
    output logic [15:0]         ig2cq_pd,
    input  logic                cq_pop,
    input  logic                lat_rd_pop,
    output logic                op_done,
    output logic                sched_clk_en,
    output logic [31:0]         req_cnt,
    output logic                credit_err
);
    localparam int CRW  = $clog2(LAT_DEPTH + 1);
    localparam int CQW  = $clog2(CQ_DEPTH + 1);
    // Wide enough for credits (<=511) and size+1 (<=256) without truncation.
    localparam int CMPW = 10;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t              state_q, state_d;
    logic [CRW-1:0]      credits_q, credits_d;
    logic [CQW-1:0]      cq_out_q, cq_out_d;
    logic                dma_pend_q, dma_pend_d;
    logic                cq_pend_q, cq_pend_d;
    logic [ADDR_W+14:0]  req_pd_q, req_pd_d;
    logic [15:0]         cq_pd_q, cq_pd_d;
    logic [31:0]         req_cnt_q, req_cnt_d;
    logic                err_q, err_d;

    logic [8:0]          size_p1;
    logic                accept, dma_hs, cq_hs, pop_eff, start, err_now;

    // Handshake qualifiers and command admission.
    always_comb begin
        size_p1  = {1'b0, cmd_size} + 9'd1;
        cmd_prdy = (state_q == RUN) && !dma_pend_q && !cq_pend_q
                   && (CMPW'(credits_q) >= CMPW'(size_p1))
                   && (cq_out_q < CQW'(CQ_DEPTH));
        accept   = cmd_pvld && cmd_prdy;
        dma_hs   = dma_pend_q && dma_rd_req_prdy;
        cq_hs    = cq_pend_q && ig2cq_prdy;
        // A pop into a full pool is dropped unless an accept frees room the same cycle.
        pop_eff  = lat_rd_pop && !((credits_q == CRW'(LAT_DEPTH)) && !accept);
        start    = (state_q == IDLE) && op_en;
        err_now  = (lat_rd_pop && !pop_eff)
                   || (cq_pop && !cq_hs && (cq_out_q == '0))
                   || (cmd_pvld && (state_q == RUN) && (CMPW'(size_p1) > CMPW'(LAT_DEPTH)));
    end

    // Next-state for the layer FSM, credit pool, pend slots and counters.
    always_comb begin
        state_d    = state_q;
        credits_d  = credits_q - (accept ? CRW'(size_p1) : '0) + CRW'(pop_eff);
        cq_out_d   = cq_out_q;
        dma_pend_d = dma_pend_q && !dma_hs;
        cq_pend_d  = cq_pend_q && !cq_hs;
        req_pd_d   = req_pd_q;
        cq_pd_d    = cq_pd_q;
        req_cnt_d  = start ? 32'd0 : req_cnt_q + {31'd0, dma_hs};
        err_d      = (start ? 1'b0 : err_q) | err_now;

        if (accept) begin
            dma_pend_d = 1'b1;
            cq_pend_d  = 1'b1;
            req_pd_d   = {7'b0, cmd_size, cmd_addr};
            cq_pd_d    = {cmd_last, 7'b0, cmd_size};
        end

        case ({cq_hs, cq_pop})
            2'b10:   cq_out_d = cq_out_q + CQW'(1);
            2'b01:   cq_out_d = (cq_out_q == '0) ? cq_out_q : cq_out_q - CQW'(1);
            default: cq_out_d = cq_out_q;
        endcase

        // DRAIN looks at next-cycle values so DONE follows the final return directly.
        case (state_q)
            IDLE:    if (op_en) state_d = RUN;
            RUN:     if (accept && cmd_last) state_d = DRAIN;
            DRAIN:   if ((credits_d == CRW'(LAT_DEPTH)) && (cq_out_d == '0)
                         && !dma_pend_d && !cq_pend_d) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q    <= IDLE;
            credits_q  <= CRW'(LAT_DEPTH);
            cq_out_q   <= '0;
            dma_pend_q <= 1'b0;
            cq_pend_q  <= 1'b0;
            req_pd_q   <= '0;
            cq_pd_q    <= '0;
            req_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            credits_q  <= credits_d;
            cq_out_q   <= cq_out_d;
            dma_pend_q <= dma_pend_d;
            cq_pend_q  <= cq_pend_d;
            req_pd_q   <= req_pd_d;
            cq_pd_q    <= cq_pd_d;
            req_cnt_q  <= req_cnt_d;
            err_q      <= err_d;
        end
    end

    // Output mapping.
    always_comb begin
        dma_rd_req_pvld = dma_pend_q;
        dma_rd_req_pd   = req_pd_q;
        ig2cq_pvld      = cq_pend_q;
        ig2cq_pd        = cq_pd_q;
        op_done         = (state_q == DONE);
        req_cnt         = req_cnt_q;
        credit_err      = err_q;
        sched_clk_en    = op_en || (state_q != IDLE) || lat_rd_pop || cq_pop;
    end
endmodule

// File: tb/tb_nv_nvdla_sdp_brdma_issue_sched.sv
// Directed bench for the BRDMA issue scheduler (LAT_DEPTH=160, CQ_DEPTH=4).
module tb_nv_nvdla_sdp_brdma_issue_sched;
    localparam int ADDR_W = 64;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              op_en = 1'b0;
    logic              cmd_pvld = 1'b0;
    logic              cmd_prdy;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [7:0]        cmd_size = '0;
    logic              cmd_last = 1'b0;
    logic              dma_pvld;
    logic              dma_prdy = 1'b1;
    logic [ADDR_W+14:0] dma_pd;
    logic              cq_pvld;
    logic              cq_prdy = 1'b1;
    logic [15:0]       cq_pd;
    logic              cq_pop = 1'b0;
    logic              lat_pop = 1'b0;
    logic              op_done;
    logic              clk_en;
    logic [31:0]       req_cnt;
    logic              credit_err;

    int checks = 0;
    int failures = 0;
    logic [ADDR_W+14:0] held_pd;

    nv_nvdla_sdp_brdma_issue_sched #(.ADDR_W(ADDR_W), .LAT_DEPTH(160), .CQ_DEPTH(4)) dut (
        .nvdla_core_clk_mgated(clk),
        .nvdla_core_rstn(rstn),
        .op_en(op_en),
        .cmd_pvld(cmd_pvld),
        .cmd_prdy(cmd_prdy),
        .cmd_addr(cmd_addr),
        .cmd_size(cmd_size),
        .cmd_last(cmd_last),
        .dma_rd_req_pvld(dma_pvld),
        .dma_rd_req_prdy(dma_prdy),
        .dma_rd_req_pd(dma_pd),
        .ig2cq_pvld(cq_pvld),
        .ig2cq_prdy(cq_prdy),
        .ig2cq_pd(cq_pd),
        .cq_pop(cq_pop),
        .lat_rd_pop(lat_pop),
        .op_done(op_done),
        .sched_clk_en(clk_en),
        .req_cnt(req_cnt),
        .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_layer();
        op_en = 1'b1;
        tick();
        op_en = 1'b0;
        chk("state_run", 128'(dut.state_q), 128'd1);
    endtask

    // Return n_lat atoms and n_cq context entries (n_lat >= n_cq), expect op_done right after.
    task automatic drain(input int n_lat, input int n_cq);
        for (int i = 0; i < n_lat; i++) begin
            lat_pop = 1'b1;
            cq_pop  = (i < n_cq);
            if (op_done !== 1'b0) chk("op_done_early", 128'(op_done), 128'd0);
            tick();
        end
        lat_pop = 1'b0;
        cq_pop  = 1'b0;
        chk("op_done_pulse", 128'(op_done), 128'd1);
        tick();
        chk("op_done_clear", 128'(op_done), 128'd0);
        chk("state_idle", 128'(dut.state_q), 128'd0);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        chk("rst_dma_pvld", 128'(dma_pvld), 128'd0);
        chk("rst_cq_pvld", 128'(cq_pvld), 128'd0);
        chk("rst_op_done", 128'(op_done), 128'd0);
        chk("rst_err", 128'(credit_err), 128'd0);
        chk("rst_req_cnt", 128'(req_cnt), 128'd0);
        chk("rst_credits", 128'(dut.credits_q), 128'd160);
        chk("rst_cmd_prdy", 128'(cmd_prdy), 128'd0);
        chk("rst_clk_en", 128'(clk_en), 128'd0);
        rstn = 1'b1;
        tick();

        // 1) Three size=15 commands, readies high
        op_en = 1'b1;
        #1;
        chk("clk_en_op_en", 128'(clk_en), 128'd1);
        start_layer();
        for (int i = 0; i < 3; i++) begin
            cmd_pvld = 1'b1;
            cmd_addr = 64'h1000_0000 + 64'(i * 64);
            cmd_size = 8'd15;
            cmd_last = (i == 2);
            chk("t1_prdy", 128'(cmd_prdy), 128'd1);
            tick();
            cmd_pvld = 1'b0;
            chk("t1_dma_pvld", 128'(dma_pvld), 128'd1);
            chk("t1_dma_pd", 128'(dma_pd), {49'd0, 7'd0, 8'd15, 64'h1000_0000 + 64'(i * 64)});
            chk("t1_cq_pvld", 128'(cq_pvld), 128'd1);
            chk("t1_cq_pd", 128'(cq_pd), 128'({(i == 2), 7'd0, 8'd15}));
            chk("t1_prdy_blocked", 128'(cmd_prdy), 128'd0);
            tick();
            chk("t1_dma_clr", 128'(dma_pvld), 128'd0);
            chk("t1_cq_clr", 128'(cq_pvld), 128'd0);
        end
        chk("t1_req_cnt", 128'(req_cnt), 128'd3);
        chk("t1_credits", 128'(dut.credits_q), 128'd112);
        chk("t1_state_drain", 128'(dut.state_q), 128'd2);
        drain(48, 3);

        // 2) Credit stall
        start_layer();
        for (int i = 0; i < 2; i++) begin
            cmd_pvld = 1'b1; cmd_addr = 64'h2000 + 64'(i); cmd_size = 8'd79; cmd_last = 1'b0;
            chk("t2_prdy79", 128'(cmd_prdy), 128'd1);
            tick();
            cmd_pvld = 1'b0;
            tick();
        end
        chk("t2_credits0", 128'(dut.credits_q), 128'd0);
        cmd_pvld = 1'b1; cmd_addr = 64'h2100; cmd_size = 8'd0; cmd_last = 1'b1;
        chk("t2_stall_a", 128'(cmd_prdy), 128'd0);
        tick();
        chk("t2_stall_b", 128'(cmd_prdy), 128'd0);
        lat_pop = 1'b1;
        chk("t2_stall_pop_cycle", 128'(cmd_prdy), 128'd0);
        tick();
        lat_pop = 1'b0;
        chk("t2_prdy_after_pop", 128'(cmd_prdy), 128'd1);
        tick();
        cmd_pvld = 1'b0;
        chk("t2_state_drain", 128'(dut.state_q), 128'd2);
        tick();
        chk("t2_req_cnt", 128'(req_cnt), 128'd3);
        drain(160, 3);

        // 3) Split handshake: DMA ready low for 5 cycles
        start_layer();
        dma_prdy = 1'b0;
        cmd_pvld = 1'b1; cmd_addr = 64'hABCD_0000; cmd_size = 8'd7; cmd_last = 1'b0;
        tick();
        cmd_addr = 64'hABCD_0100; cmd_size = 8'd0; cmd_last = 1'b1;
        held_pd = {7'd0, 8'd7, 64'hABCD_0000};
        chk("t3_both_valid_dma", 128'(dma_pvld), 128'd1);
        chk("t3_both_valid_cq", 128'(cq_pvld), 128'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_cq_cleared", 128'(cq_pvld), 128'd0);
            chk("t3_dma_held", 128'(dma_pvld), 128'd1);
            chk("t3_pd_stable", 128'(dma_pd), 128'(held_pd));
            chk("t3_prdy_low", 128'(cmd_prdy), 128'd0);
        end
        tick();
        dma_prdy = 1'b1;
        chk("t3_prdy_low_hs", 128'(cmd_prdy), 128'd0);
        tick();
        chk("t3_dma_clr", 128'(dma_pvld), 128'd0);
        chk("t3_req_cnt", 128'(req_cnt), 128'd1);
        chk("t3_prdy_back", 128'(cmd_prdy), 128'd1);
        tick();
        cmd_pvld = 1'b0;
        tick();
        drain(9, 2);

        // 4) Accept and pop together, then saturating pop
        start_layer();
        cmd_pvld = 1'b1; cmd_addr = 64'h4000; cmd_size = 8'd149; cmd_last = 1'b0;
        tick();
        cmd_pvld = 1'b0;
        tick();
        chk("t4_credits10", 128'(dut.credits_q), 128'd10);
        cmd_pvld = 1'b1; cmd_addr = 64'h4100; cmd_size = 8'd3; cmd_last = 1'b1;
        lat_pop = 1'b1;
        tick();
        cmd_pvld = 1'b0;
        lat_pop = 1'b0;
        chk("t4_credits7", 128'(dut.credits_q), 128'd7);
        tick();
        drain(153, 2);
        chk("t4_err_clean", 128'(credit_err), 128'd0);
        lat_pop = 1'b1;
        tick();
        lat_pop = 1'b0;
        chk("t4_credits_sat", 128'(dut.credits_q), 128'd160);
        chk("t4_err_set", 128'(credit_err), 128'd1);

        // 5) Context queue full at CQ_DEPTH=4
        start_layer();
        chk("t5_err_cleared", 128'(credit_err), 128'd0);
        for (int i = 0; i < 4; i++) begin
            cmd_pvld = 1'b1; cmd_addr = 64'h5000 + 64'(i); cmd_size = 8'd0; cmd_last = 1'b0;
            tick();
            cmd_pvld = 1'b0;
            tick();
        end
        cmd_pvld = 1'b1; cmd_addr = 64'h5100; cmd_last = 1'b1;
        chk("t5_full_stall", 128'(cmd_prdy), 128'd0);
        tick();
        chk("t5_full_stall2", 128'(cmd_prdy), 128'd0);
        cq_pop = 1'b1;
        tick();
        cq_pop = 1'b0;
        chk("t5_prdy_after_pop", 128'(cmd_prdy), 128'd1);
        tick();
        cmd_pvld = 1'b0;
        tick();
        chk("t5_req_cnt", 128'(req_cnt), 128'd5);
        drain(5, 4);

        // 6) Reset mid-RUN with pends valid
        start_layer();
        cmd_pvld = 1'b1; cmd_addr = 64'h6000; cmd_size = 8'd10; cmd_last = 1'b0;
        tick();
        cmd_pvld = 1'b0;
        tick();
        chk("t6_req_cnt1", 128'(req_cnt), 128'd1);
        dma_prdy = 1'b0; cq_prdy = 1'b0;
        cmd_pvld = 1'b1; cmd_addr = 64'h6100;
        tick();
        cmd_pvld = 1'b0;
        chk("t6_pend_dma", 128'(dma_pvld), 128'd1);
        chk("t6_pend_cq", 128'(cq_pvld), 128'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_dma_pvld", 128'(dma_pvld), 128'd0);
        chk("t6_cq_pvld", 128'(cq_pvld), 128'd0);
        chk("t6_credits", 128'(dut.credits_q), 128'd160);
        chk("t6_state", 128'(dut.state_q), 128'd0);
        chk("t6_req_cnt", 128'(req_cnt), 128'd0);
        tick();
        rstn = 1'b1;
        dma_prdy = 1'b1; cq_prdy = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
